// File: rtl/sdam_pkg.sv
// Shared definitions for the scl/sda address+data link master.
package sdam_pkg;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FRAME_BITS = 26;
  localparam int unsigned BIT_CNT_W  = 5;

  // Frame sequencer states, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t START = 3'd1;
  localparam state_t MARK  = 3'd2;
  localparam state_t ADDR  = 3'd3;
  localparam state_t DATA  = 3'd4;
  localparam state_t GAP   = 3'd5;

endpackage

// File: rtl/sdam_rr_arb.sv
// Round-robin arbiter: searches from the pointer upward, wrapping, and
// returns a one-hot winner qualified by the sample strobe.
module sdam_rr_arb
  import sdam_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  input  logic                       i_sample,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic                       o_valid
);

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_gnt;
  logic                 w_found;

  assign w_req_dbl = {i_req, i_req};

  // First asserted request at or after the pointer; doubling avoids a modulo on the lookup.
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_req_dbl[int'(i_ptr) + i]) begin
        w_found = 1'b1;
        w_gnt[(int'(i_ptr) + i) % NUM_REQ] = 1'b1;
      end
    end
  end

  // Only report a winner on the sample strobe.
  always_comb begin
    o_gnt   = i_sample ? w_gnt : '0;
    o_valid = i_sample & w_found;
  end

endmodule

// File: rtl/sdam_link_master.sv
// Transmit-side master for the two-wire scl/sda link: arbitrates requesters,
// latches the winner's address/data and serialises start, marker, address,
// data (LSB first) and an idle gap onto sda under a free-running scl.
module sdam_link_master
  import sdam_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned GAP_BITS = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      done,
  output logic                      busy,
  output logic                      scl,
  output logic                      sda
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam int unsigned GAP_W = $clog2(GAP_BITS + 1);
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP_BITS - 1);
  localparam logic [PTR_W-1:0]     PTR_LAST  = PTR_W'(NUM_REQ - 1);
  localparam logic [BIT_CNT_W-1:0] ADDR_LAST = BIT_CNT_W'(ADDR_W - 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_W - 1);

  logic [DIV_W-1:0]         r_div_cnt;
  logic                     r_scl;
  logic                     r_sda;
  logic [NUM_REQ-1:0]       r_gnt;
  logic                     r_done;
  logic                     r_busy;
  state_t                   r_state;
  logic [BIT_CNT_W-1:0]     r_bit_cnt;
  logic [GAP_W-1:0]         r_gap_cnt;
  logic [PTR_W-1:0]         r_ptr;
  logic [ADDR_W+DATA_W-1:0] r_shift;

  logic               w_tick;
  logic               w_sample;
  logic [NUM_REQ-1:0] w_win;
  logic               w_valid;
  logic [PTR_W-1:0]   w_idx;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;

  // Bit boundary is the clk edge where scl falls; requests are sampled in IDLE or on the last gap bit.
  always_comb begin
    w_tick   = r_scl && (r_div_cnt == DIV_LAST);
    w_sample = w_tick && ((r_state == IDLE) || ((r_state == GAP) && (r_gap_cnt == GAP_LAST)));
  end

  sdam_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .i_sample (w_sample),
    .o_gnt    (w_win),
    .o_valid  (w_valid)
  );

  // Encode the one-hot winner and select its address/data.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win[i]) w_idx = PTR_W'(i);
    end
    w_addr = req_addr[w_idx*ADDR_W +: ADDR_W];
    w_data = req_data[w_idx*DATA_W +: DATA_W];
  end

  // Free-running scl divider: CLK_DIV clks low, then CLK_DIV clks high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_scl     <= 1'b0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
      r_scl     <= ~r_scl;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Frame sequencer: all sda changes land on a tick so sda is stable at scl rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sda     <= 1'b1;
      r_gnt     <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_ptr     <= '0;
      r_shift   <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= 1'b0;
      if (w_tick) begin
        if (w_valid) begin
          // Grant: latch the winner so later input changes cannot reach the frame.
          r_gnt     <= w_win;
          r_shift   <= {w_data, w_addr};
          r_ptr     <= (w_idx == PTR_LAST) ? '0 : w_idx + 1'b1;
          r_busy    <= 1'b1;
          r_sda     <= 1'b0;
          r_state   <= START;
          r_bit_cnt <= '0;
          r_gap_cnt <= '0;
        end else begin
          unique case (r_state)
            IDLE: r_sda <= 1'b1;
            START: begin
              r_sda   <= 1'b1;
              r_state <= MARK;
            end
            MARK: begin
              r_sda     <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= '0;
              r_state   <= ADDR;
            end
            ADDR: begin
              // After addr[7] the shifter already presents data[0].
              r_sda     <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= (r_bit_cnt == ADDR_LAST) ? '0 : r_bit_cnt + 1'b1;
              if (r_bit_cnt == ADDR_LAST) r_state <= DATA;
            end
            DATA: begin
              if (r_bit_cnt == DATA_LAST) begin
                r_done    <= 1'b1;
                r_sda     <= 1'b1;
                r_gap_cnt <= '0;
                r_state   <= GAP;
              end else begin
                r_sda     <= r_shift[0];
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
            GAP: begin
              if (r_gap_cnt == GAP_LAST) begin
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end else begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
              end
            end
            default: begin
              r_sda   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          endcase
        end
      end
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign busy = r_busy;
  assign scl  = r_scl;
  assign sda  = r_sda;

endmodule

// File: doc/sdam_link_master.md
Name: sdam_link_master

Overview:
- Transmit-side controller for the two-wire scl/sda address+data link consumed by the team's serial address/data receiver.
- Arbitrates round-robin among NUM_REQ local requesters and latches the winner's 8-bit address and 16-bit data.
- Generates a free-running scl and sequences the frame onto sda: start, marker, address, data, then an inter-frame gap.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLK_DIV, 2, clk cycles per scl half-period (>=1); one bit period = 2*CLK_DIV clk cycles.
- GAP_BITS, 2, minimum idle bit periods (sda=1) after each frame (>=1).

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset; asynchronous, active-low
- req  input  NUM_REQ  level request per requester
- req_addr  input  NUM_REQ*8  address for requester i in bits [8i+7:8i]
- req_data  input  NUM_REQ*16  data for requester i in bits [16i+15:16i]
- gnt  output  NUM_REQ  one-hot, one-clk pulse when requester's addr/data are latched
- done  output  1  one-clk pulse when the last data bit period completes
- busy  output  1  high from grant through end of gap
- scl  output  1  serial clock, free-running
- sda  output  1  serial data, idle high

Behaviour:
- Reset (async, reset_n low): scl=0, sda=1, gnt=0, done=0, busy=0, state=IDLE, rr pointer=0, all counters 0. Assertion mid-frame aborts immediately; no partial completion; done is not pulsed.
- scl: low for CLK_DIV clks, then high for CLK_DIV clks, repeating from reset release. The bit boundary ("tick") is the clk edge where scl goes 1->0.
- All outputs are registered. sda changes only at a tick and is stable across the scl rising edge where the receiver samples.
- States: IDLE, START, MARK, ADDR, DATA, GAP.
- IDLE: sda=1. At each tick, if any req bit is high: pick the winner by round-robin; latch its addr/data; pulse gnt[winner] for the first clk after the tick; busy=1; enter START. If no req bit is high, stay in IDLE.
- START: sda=0 for one bit period, then MARK.
- MARK: sda=1 for one bit period, then ADDR.
- ADDR: 8 bit periods; sda = addr[0] first through addr[7] (LSB first); bit_cnt 0..7, then DATA.
- DATA: 16 bit periods; data[0] first through data[15]. At the tick ending data[15]: pulse done for one clk, enter GAP.
- GAP: sda=1 for GAP_BITS bit periods. busy drops at the tick ending the gap; return to IDLE. A request pending at that same tick is granted at that tick, so back-to-back frames have exactly GAP_BITS idle bits.
- Frame length: 26 bit periods plus the gap. The grant-to-done latency is 26*2*CLK_DIV clks.
- Round-robin:
  - Search order starts at the rr pointer and wraps modulo NUM_REQ.
  - After a grant, pointer = winner+1 mod NUM_REQ.
  - req is sampled only at an IDLE tick. A request withdrawn before that tick is never granted.
  - A requester that keeps req high after gnt is treated as a new request and is queued behind the others.
- Latched addr/data are immune to input changes after the grant.

Decomposition:
- Shared package sdam_pkg holds:
  - state enum {IDLE, START, MARK, ADDR, DATA, GAP};
  - ADDR_W=8, DATA_W=16, FRAME_BITS=26;
  - bit_cnt width of 5.
- Sub-module sdam_rr_arb (parameter NUM_REQ) is natural. It takes req, pointer and a sample strobe, and returns a one-hot winner plus a valid flag.
- The top level owns the clock divider, the FSM and the shift register.

Test Plan:
- Single request, CLK_DIV=2: req[1] with addr 0xA5, data 0x3C96.
  - Required gnt=0010.
  - Required sda per bit: 0,1, then 1,0,1,0,0,1,0,1, then 0,1,1,0,1,0,0,1,0,0,1,1,1,1,0,0.
  - done 104 clks after gnt.
  - busy clears after 2 more bit periods.
- All four requesters held high: grants in order 0,1,2,3,0. Every pair of frames is separated by exactly GAP_BITS=2 sda-high bits.
- Pointer=2 after one grant; req=0011 -> gnt 0001 then 0010. req[2] asserted and dropped between ticks -> never granted.
- Change req_addr/req_data of the granted requester on the clk after gnt -> transmitted frame still carries the latched values.
- reset_n low during DATA bit 5 -> immediately scl=0, sda=1, busy=0, no done. After release, req[3] is granted first (pointer 0 search).
- Loopback: connect scl/sda to the team's receiver model with CLK_DIV=3 and 20 random frames -> receiver aout/dout match every granted addr/data.
